// File: rtl/mc_exec_sequencer_if.sv
// mc_exec_sequencer_if: handshake and bus bundle for the multi-cycle sequencer.
//
// Signal groups:
//   decode in : in_valid/in_ready, opcode, funct3, rd_idx, rs1_val, rs2_val, imm, pc
//   alu       : alu_en (strobe out), alu_result (combinational result in)
//   data mem  : mem_req/mem_ready, mem_we, mem_addr, mem_wdata, mem_wstrb, mem_rdata
//   reg file  : rd_we, rd_waddr, rd_wdata
//   pc        : redirect, redirect_pc
//   status    : err
//
// Modports: master = the sequencer, slave = decoder/ALU/memory/regfile side.
interface mc_exec_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [4:0]        rd_idx;
  logic [XLEN-1:0]   rs1_val;
  logic [XLEN-1:0]   rs2_val;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   pc;
  logic              alu_en;
  logic [XLEN-1:0]   alu_result;
  logic              mem_req;
  logic              mem_ready;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_rdata;
  logic              rd_we;
  logic [4:0]        rd_waddr;
  logic [XLEN-1:0]   rd_wdata;
  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;
  logic              err;

  modport master (
    input  in_valid, opcode, funct3, rd_idx, rs1_val, rs2_val, imm, pc,
    input  alu_result, mem_ready, mem_rdata,
    output in_ready, alu_en, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output rd_we, rd_waddr, rd_wdata, redirect, redirect_pc, err
  );

  modport slave (
    output in_valid, opcode, funct3, rd_idx, rs1_val, rs2_val, imm, pc,
    output alu_result, mem_ready, mem_rdata,
    input  in_ready, alu_en, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  rd_we, rd_waddr, rd_wdata, redirect, redirect_pc, err
  );
endinterface

// File: rtl/mc_exec_sequencer.sv
// mc_exec_sequencer: multi-cycle EXEC/MEM/WB sequencer for the RV core.
//
// Accepts one decoded instruction per valid/ready handshake in IDLE, then walks
// EXEC (1 cycle) -> [MEM (until mem_ready or timeout)] -> WB (1 cycle) -> IDLE.
//
// Ports:
//   clk            clock
//   rst            asynchronous, active-high reset
//   bus (master)   decode input, ALU strobe, data-memory port, regfile write,
//                  PC redirect and error strobe (see mc_exec_sequencer_if)
//
// Parameters:
//   XLEN         datapath width, 32 or 64
//   MEM_TIMEOUT  MEM wait cycles (mem_ready low) before a bus error, 1..255
//
// Build option:
//   MISALIGN_TRAP_EN  defined: misaligned load/store raises err and skips MEM.
//                     undefined: misaligned address is aligned down silently.
//
// Every output is decoded from registered state, so nothing combinational
// passes from the bus inputs to the bus outputs.
module mc_exec_sequencer #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 rst,
  mc_exec_sequencer_if.master bus
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OB = $clog2(NB);

  typedef logic [XLEN-1:0] word_t;
  typedef logic [NB-1:0]   strb_t;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [1:0] {StIdle, StExec, StMem, StWb} state_e;

  state_e      state_q, state_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_idx_q, rd_idx_d;
  word_t       rs1_q, rs1_d;
  word_t       rs2_q, rs2_d;
  word_t       imm_q, imm_d;
  word_t       pc_q, pc_d;
  word_t       result_q, result_d;
  word_t       target_q, target_d;
  word_t       addr_q, addr_d;
  logic        taken_q, taken_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  // Opcode classes of the latched instruction.
  logic is_load, is_store, is_mem, is_alu, is_jump, is_branch, writes_rd;

  always_comb begin
    is_load   = (opcode_q == OpLoad);
    is_store  = (opcode_q == OpStore);
    is_mem    = is_load | is_store;
    is_alu    = (opcode_q == OpOp) | (opcode_q == OpOpImm);
    is_jump   = (opcode_q == OpJal) | (opcode_q == OpJalr);
    is_branch = (opcode_q == OpBranch);
    writes_rd = is_alu | is_load | is_jump | (opcode_q == OpLui) | (opcode_q == OpAuipc);
  end

  // Opcode/funct3 legality.
  logic legal;

  always_comb begin
    legal = 1'b1;
    case (opcode_q)
      OpOp, OpOpImm, OpLui, OpAuipc, OpJal: legal = 1'b1;
      OpJalr:   legal = (funct3_q == 3'b000);
      OpBranch: legal = (funct3_q[2:1] != 2'b01);
      OpLoad: begin
        case (funct3_q)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
          3'b011, 3'b110:                         legal = (XLEN == 64);
          default:                                legal = 1'b0;
        endcase
      end
      OpStore: legal = (funct3_q == 3'b011) ? (XLEN == 64) : !funct3_q[2];
      default: legal = 1'b0;
    endcase
  end

  // Branch condition.
  logic taken;

  always_comb begin
    taken = 1'b0;
    case (funct3_q)
      3'b000:  taken = (rs1_q == rs2_q);
      3'b001:  taken = (rs1_q != rs2_q);
      3'b100:  taken = ($signed(rs1_q) <  $signed(rs2_q));
      3'b101:  taken = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  taken = (rs1_q <  rs2_q);
      3'b111:  taken = (rs1_q >= rs2_q);
      default: taken = 1'b0;
    endcase
  end

  // EXEC arithmetic; all modulo 2^XLEN by construction.
  word_t sum_ri, pc_imm, pc_4, align_mask, addr_exec;
  logic  misalign;

  always_comb begin
    sum_ri     = rs1_q + imm_q;
    pc_imm     = pc_q + imm_q;
    pc_4       = pc_q + word_t'(4);
    // funct3[1:0] encodes log2 of the access size for both loads and stores.
    align_mask = word_t'((32'd1 << funct3_q[1:0]) - 32'd1);
`ifdef MISALIGN_TRAP_EN
    misalign   = |(sum_ri & align_mask);
    addr_exec  = sum_ri;
`else
    misalign   = 1'b0;
    addr_exec  = sum_ri & ~align_mask;
`endif
  end

  // Store lane formatting and load extraction at the byte offset.
  logic [OB-1:0] off;
  word_t         st_wdata;
  strb_t         st_wstrb;
  word_t         ld_shift;
  word_t         ld_data;

  always_comb begin
    off = addr_q[OB-1:0];
    case (funct3_q[1:0])
      2'b00: begin
        st_wdata = {NB{rs2_q[7:0]}};
        st_wstrb = strb_t'(1) << off;
      end
      2'b01: begin
        st_wdata = {(NB/2){rs2_q[15:0]}};
        st_wstrb = strb_t'(3) << off;
      end
      2'b10: begin
        st_wdata = {(NB/4){rs2_q[31:0]}};
        st_wstrb = strb_t'(15) << off;
      end
      default: begin
        st_wdata = rs2_q;
        st_wstrb = '1;
      end
    endcase

    ld_shift = bus.mem_rdata >> {off, 3'b000};
    case (funct3_q)
      3'b000:  ld_data = word_t'($signed(ld_shift[7:0]));
      3'b001:  ld_data = word_t'($signed(ld_shift[15:0]));
      3'b010:  ld_data = word_t'($signed(ld_shift[31:0]));
      3'b100:  ld_data = word_t'(ld_shift[7:0]);
      3'b101:  ld_data = word_t'(ld_shift[15:0]);
      3'b110:  ld_data = word_t'(ld_shift[31:0]);
      default: ld_data = ld_shift;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    funct3_d = funct3_q;
    rd_idx_d = rd_idx_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    imm_d    = imm_q;
    pc_d     = pc_q;
    result_d = result_q;
    target_d = target_q;
    addr_d   = addr_q;
    taken_d  = taken_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          opcode_d = bus.opcode;
          funct3_d = bus.funct3;
          rd_idx_d = bus.rd_idx;
          rs1_d    = bus.rs1_val;
          rs2_d    = bus.rs2_val;
          imm_d    = bus.imm;
          pc_d     = bus.pc;
          taken_d  = 1'b0;
          err_d    = 1'b0;
          cnt_d    = '0;
          state_d  = StExec;
        end
      end

      StExec: begin
        state_d = StWb;
        err_d   = !legal || (is_mem && misalign);
        case (opcode_q)
          OpOp, OpOpImm: result_d = bus.alu_result;
          OpLui:         result_d = imm_q;
          OpAuipc:       result_d = pc_imm;
          OpJal: begin
            result_d = pc_4;
            target_d = pc_imm;
          end
          OpJalr: begin
            result_d = pc_4;
            target_d = sum_ri & ~word_t'(1);
          end
          OpBranch: begin
            target_d = pc_imm;
            taken_d  = taken;
          end
          OpLoad, OpStore: begin
            addr_d = addr_exec;
            cnt_d  = '0;
            if (legal && !misalign) state_d = StMem;
          end
          default: ;
        endcase
      end

      StMem: begin
        if (bus.mem_ready) begin
          if (is_load) result_d = ld_data;
          state_d = StWb;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == 8'(MEM_TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = StWb;
          end
        end
      end

      StWb: begin
        cnt_d   = '0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      opcode_q <= '0;
      funct3_q <= '0;
      rd_idx_q <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
      result_q <= '0;
      target_q <= '0;
      addr_q   <= '0;
      taken_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      funct3_q <= funct3_d;
      rd_idx_q <= rd_idx_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      imm_q    <= imm_d;
      pc_q     <= pc_d;
      result_q <= result_d;
      target_q <= target_d;
      addr_q   <= addr_d;
      taken_q  <= taken_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs, decoded from registered state only.
  logic in_exec, in_mem, in_wb;

  always_comb begin
    in_exec = (state_q == StExec);
    in_mem  = (state_q == StMem);
    in_wb   = (state_q == StWb);

    bus.in_ready    = (state_q == StIdle);
    bus.alu_en      = in_exec && is_alu;

    bus.mem_req     = in_mem;
    bus.mem_we      = in_mem && is_store;
    bus.mem_addr    = in_mem ? addr_q : '0;
    bus.mem_wdata   = (in_mem && is_store) ? st_wdata : '0;
    bus.mem_wstrb   = (in_mem && is_store) ? st_wstrb : '0;

    bus.rd_we       = in_wb && writes_rd && (rd_idx_q != 5'd0) && !err_q;
    bus.rd_waddr    = in_wb ? rd_idx_q : '0;
    bus.rd_wdata    = in_wb ? result_q : '0;

    bus.redirect    = in_wb && !err_q && (is_jump || (is_branch && taken_q));
    bus.redirect_pc = in_wb ? target_q : '0;

    bus.err         = in_wb && err_q;
  end

endmodule

// File: tb/tb_mc_exec_sequencer.sv
// Self-checking bench for mc_exec_sequencer (XLEN=32, MEM_TIMEOUT=4).
// Each instruction pushes its expected write-back record onto a queue; the
// observed record is assembled while the instruction runs and is compared
// against the popped entry once the sequencer returns to IDLE.
module tb_mc_exec_sequencer;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned MEM_TIMEOUT = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mc_exec_sequencer_if #(.XLEN(XLEN)) bus ();

  mc_exec_sequencer #(
    .XLEN       (XLEN),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rdata;
    int          waits;   // mem_ready rises on req cycle index 'waits'
  } instr_t;

  typedef struct packed {
    logic        rd_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        redir;
    logic [31:0] rpc;
    logic        err;
    int          wb_cyc;   // cycle after accept with a visible WB event, 0 = none
    int          idle_cyc; // cycle after accept where in_ready returns
    int          alu_n;
    int          mem_n;
    logic        st;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mwstrb;
  } res_t;

  res_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic instr_t mk_i(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [4:0] rd, input logic [31:0] rs1,
                                  input logic [31:0] rs2, input logic [31:0] imm,
                                  input logic [31:0] pc, input logic [31:0] alu,
                                  input logic [31:0] rdata, input int waits);
    instr_t i;
    i.op = op; i.f3 = f3; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.imm = imm;
    i.pc = pc; i.alu = alu; i.rdata = rdata; i.waits = waits;
    return i;
  endfunction

  function automatic res_t mk_r(input logic rd_we, input logic [4:0] waddr,
                                input logic [31:0] wdata, input logic redir,
                                input logic [31:0] rpc, input logic err, input int wb_cyc,
                                input int idle_cyc, input int alu_n, input int mem_n,
                                input logic st, input logic [31:0] maddr,
                                input logic [31:0] mwdata, input logic [3:0] mwstrb);
    res_t r;
    r.rd_we = rd_we; r.waddr = waddr; r.wdata = wdata; r.redir = redir; r.rpc = rpc;
    r.err = err; r.wb_cyc = wb_cyc; r.idle_cyc = idle_cyc; r.alu_n = alu_n;
    r.mem_n = mem_n; r.st = st; r.maddr = maddr; r.mwdata = mwdata; r.mwstrb = mwstrb;
    return r;
  endfunction

  task automatic drive_instr(input instr_t ins);
    bus.in_valid   = 1'b1;
    bus.opcode     = ins.op;
    bus.funct3     = ins.f3;
    bus.rd_idx     = ins.rd;
    bus.rs1_val    = ins.rs1;
    bus.rs2_val    = ins.rs2;
    bus.imm        = ins.imm;
    bus.pc         = ins.pc;
    bus.alu_result = ins.alu;
    bus.mem_rdata  = ins.rdata;
    bus.mem_ready  = 1'b0;
  endtask

  task automatic run(input string name, input instr_t ins, input res_t ex);
    res_t ob;
    res_t ev;
    int   cyc;
    bit   done;
    int   unstable;
    ob       = '0;
    unstable = 0;
    exp_q.push_back(ex);

    @(negedge clk);
    drive_instr(ins);
    check({name, ".in_ready"}, bus.in_ready, 1);
    @(posedge clk);

    cyc  = 0;
    done = 0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      bus.in_valid  = 1'b0;
      bus.mem_ready = 1'b0;
      if (bus.alu_en) ob.alu_n++;
      if (bus.mem_req) begin
        if (ob.mem_n == 0) begin
          ob.maddr  = bus.mem_addr;
          ob.st     = bus.mem_we;
          ob.mwdata = bus.mem_wdata;
          ob.mwstrb = bus.mem_wstrb;
        end else if ({bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_wstrb} !==
                     {ob.maddr, ob.st, ob.mwdata, ob.mwstrb}) begin
          unstable++;
        end
        bus.mem_ready = (ob.mem_n == ins.waits);
        ob.mem_n++;
      end
      if (bus.rd_we || bus.redirect || bus.err) begin
        ob.rd_we  = bus.rd_we;
        ob.waddr  = bus.rd_waddr;
        ob.wdata  = bus.rd_wdata;
        ob.redir  = bus.redirect;
        ob.rpc    = bus.redirect_pc;
        ob.err    = bus.err;
        ob.wb_cyc = cyc;
      end
      if (bus.in_ready) begin
        done        = 1;
        ob.idle_cyc = cyc;
      end
    end
    check({name, ".back_to_idle"}, done, 1);

    ev = exp_q.pop_front();
    check({name, ".rd_we"},    ob.rd_we,    ev.rd_we);
    check({name, ".redirect"}, ob.redir,    ev.redir);
    check({name, ".err"},      ob.err,      ev.err);
    check({name, ".wb_cycle"}, ob.wb_cyc,   ev.wb_cyc);
    check({name, ".idle_cyc"}, ob.idle_cyc, ev.idle_cyc);
    check({name, ".alu_en_n"}, ob.alu_n,    ev.alu_n);
    check({name, ".mem_req_n"}, ob.mem_n,   ev.mem_n);
    if (ev.rd_we) begin
      check({name, ".rd_waddr"}, ob.waddr, ev.waddr);
      check({name, ".rd_wdata"}, ob.wdata, ev.wdata);
    end
    if (ev.redir) check({name, ".redirect_pc"}, ob.rpc, ev.rpc);
    if (ev.mem_n != 0) begin
      check({name, ".mem_addr"},   ob.maddr, ev.maddr);
      check({name, ".mem_we"},     ob.st,    ev.st);
      check({name, ".mem_stable"}, unstable, 0);
      if (ev.st) begin
        check({name, ".mem_wdata"}, ob.mwdata, ev.mwdata);
        check({name, ".mem_wstrb"}, ob.mwstrb, ev.mwstrb);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive_instr(mk_i(7'd0, 3'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0));
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.in_ready",  bus.in_ready,  1);
    check("reset.alu_en",    bus.alu_en,    0);
    check("reset.mem_req",   bus.mem_req,   0);
    check("reset.mem_wstrb", bus.mem_wstrb, 0);
    check("reset.rd_we",     bus.rd_we,     0);
    check("reset.redirect",  bus.redirect,  0);
    check("reset.err",       bus.err,       0);
    rst = 1'b0;

    run("addi", mk_i(OP_OPIMM, 3'd0, 5'd5, 0, 0, 0, 0, 32'h42, 0, 0),
        mk_r(1, 5, 32'h42, 0, 0, 0, 2, 3, 1, 0, 0, 0, 0, 0));
    run("add_x0", mk_i(OP_OP, 3'd0, 5'd0, 1, 2, 0, 0, 32'h99, 0, 0),
        mk_r(0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0));
    run("blt", mk_i(OP_BRANCH, 3'd4, 5'd0, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 0, 0, 0),
        mk_r(0, 0, 0, 1, 32'h120, 0, 2, 3, 0, 0, 0, 0, 0, 0));
    run("bltu", mk_i(OP_BRANCH, 3'd6, 5'd0, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 0, 0, 0),
        mk_r(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0));
    run("beq", mk_i(OP_BRANCH, 3'd0, 5'd0, 5, 5, 32'h8, 32'h600, 0, 0, 0),
        mk_r(0, 0, 0, 1, 32'h608, 0, 2, 3, 0, 0, 0, 0, 0, 0));
    run("bge_neg", mk_i(OP_BRANCH, 3'd5, 5'd0, 32'hFFFF_FFFF, 1, 32'h8, 32'h600, 0, 0, 0),
        mk_r(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0));
    run("sb", mk_i(OP_STORE, 3'd0, 5'd0, 32'h1000, 32'hAB, 3, 0, 0, 0, 2),
        mk_r(0, 0, 0, 0, 0, 0, 0, 6, 0, 3, 1, 32'h1003, 32'hABAB_ABAB, 4'b1000));
    run("sh", mk_i(OP_STORE, 3'd1, 5'd0, 32'h1000, 32'hCAFE_1234, 6, 0, 0, 0, 0),
        mk_r(0, 0, 0, 0, 0, 0, 0, 4, 0, 1, 1, 32'h1006, 32'h1234_1234, 4'b1100));
    run("sw", mk_i(OP_STORE, 3'd2, 5'd0, 32'h1000, 32'h1122_3344, 4, 0, 0, 0, 0),
        mk_r(0, 0, 0, 0, 0, 0, 0, 4, 0, 1, 1, 32'h1004, 32'h1122_3344, 4'b1111));
    run("lb", mk_i(OP_LOAD, 3'd0, 5'd7, 32'h2000, 0, 2, 0, 0, 32'h0080_0000, 0),
        mk_r(1, 7, 32'hFFFF_FF80, 0, 0, 0, 3, 4, 0, 1, 0, 32'h2002, 0, 0));
    run("lbu", mk_i(OP_LOAD, 3'd4, 5'd7, 32'h2000, 0, 2, 0, 0, 32'h0080_0000, 0),
        mk_r(1, 7, 32'h0000_0080, 0, 0, 0, 3, 4, 0, 1, 0, 32'h2002, 0, 0));
    run("lh", mk_i(OP_LOAD, 3'd1, 5'd10, 32'h2000, 0, 2, 0, 0, 32'h8001_0000, 1),
        mk_r(1, 10, 32'hFFFF_8001, 0, 0, 0, 4, 5, 0, 2, 0, 32'h2002, 0, 0));
    run("lhu", mk_i(OP_LOAD, 3'd5, 5'd11, 32'h2000, 0, 2, 0, 0, 32'h8001_0000, 0),
        mk_r(1, 11, 32'h0000_8001, 0, 0, 0, 3, 4, 0, 1, 0, 32'h2002, 0, 0));
    run("lw_timeout", mk_i(OP_LOAD, 3'd2, 5'd8, 32'h3000, 0, 0, 0, 0, 0, 255),
        mk_r(0, 0, 0, 0, 0, 1, 6, 7, 0, 4, 0, 32'h3000, 0, 0));
    run("jal", mk_i(OP_JAL, 3'd0, 5'd1, 0, 0, 32'h40, 32'h200, 0, 0, 0),
        mk_r(1, 1, 32'h204, 1, 32'h240, 0, 2, 3, 0, 0, 0, 0, 0, 0));
    run("jalr", mk_i(OP_JALR, 3'd0, 5'd2, 32'h301, 0, 32'h10, 32'h400, 0, 0, 0),
        mk_r(1, 2, 32'h404, 1, 32'h310, 0, 2, 3, 0, 0, 0, 0, 0, 0));
    run("jal_x0", mk_i(OP_JAL, 3'd0, 5'd0, 0, 0, 32'hFFFF_FF00, 32'h500, 0, 0, 0),
        mk_r(0, 0, 0, 1, 32'h400, 0, 2, 3, 0, 0, 0, 0, 0, 0));
    run("lui", mk_i(OP_LUI, 3'd0, 5'd3, 0, 0, 32'h1234_5000, 0, 0, 0, 0),
        mk_r(1, 3, 32'h1234_5000, 0, 0, 0, 2, 3, 0, 0, 0, 0, 0, 0));
    run("auipc_wrap", mk_i(OP_AUIPC, 3'd0, 5'd4, 0, 0, 32'h2000, 32'hFFFF_F000, 0, 0, 0),
        mk_r(1, 4, 32'h0000_1000, 0, 0, 0, 2, 3, 0, 0, 0, 0, 0, 0));
    run("bad_opcode", mk_i(7'h7F, 3'd0, 5'd6, 0, 0, 0, 0, 0, 0, 0),
        mk_r(0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0));
    run("bad_branch", mk_i(OP_BRANCH, 3'd2, 5'd0, 1, 1, 8, 32'h100, 0, 0, 0),
        mk_r(0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0));
    run("ld_rv32", mk_i(OP_LOAD, 3'd3, 5'd9, 32'h1000, 0, 0, 0, 0, 0, 0),
        mk_r(0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0));
`ifdef MISALIGN_TRAP_EN
    run("lw_misalign", mk_i(OP_LOAD, 3'd2, 5'd9, 32'h1000, 0, 2, 0, 0, 32'hDEAD_BEEF, 1),
        mk_r(0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0));
`else
    run("lw_misalign", mk_i(OP_LOAD, 3'd2, 5'd9, 32'h1000, 0, 2, 0, 0, 32'hDEAD_BEEF, 1),
        mk_r(1, 9, 32'hDEAD_BEEF, 0, 0, 0, 4, 5, 0, 2, 0, 32'h1000, 0, 0));
`endif

    // Reset while a load waits in MEM.
    @(negedge clk);
    drive_instr(mk_i(OP_LOAD, 3'd2, 5'd12, 32'h4000, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_mem.mem_req_before", bus.mem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mem.mem_req",  bus.mem_req,  0);
    check("rst_mem.in_ready", bus.in_ready, 1);
    check("rst_mem.rd_we",    bus.rd_we,    0);
    check("rst_mem.redirect", bus.redirect, 0);
    @(negedge clk);
    rst = 1'b0;
    run("after_rst", mk_i(OP_OPIMM, 3'd0, 5'd6, 0, 0, 0, 0, 32'h77, 0, 0),
        mk_r(1, 6, 32'h77, 0, 0, 0, 2, 3, 1, 0, 0, 0, 0, 0));

    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
